// File: rtl/lsu_pipe.sv
// lsu_pipe: pipelined load/store unit sitting between the LSU reservation
// station and the CDB. One op per cycle; loads read data memory on the accept
// edge (S1), format in S1 -> OUT, and complete two cycles after presentation.
// Stores are held in a circular store queue and written to memory only when
// the ROB commits them; flush drops in-flight ops and uncommitted stores.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   valid_i ..         op from RS (mem_read_i/mem_write_i, funct3_i, rs1_val_i,
//                      imm_i, rs2_val_i, rd_p_i, rob_tag_i); ready_o accepts it
//   valid_o ..         CDB result (result_o, rd_p_o, rob_tag_o, is_store_o,
//                      exc_o), popped by cdb_ready_i
//   commit_store_i     ROB commits the oldest queued store
//   flush_i            squash in-flight ops and uncommitted stores
//   sq_count_o         store queue occupancy
//
// Build option: define LSU_STQ_FWD_EN to forward a pending word-sized store
// to a matching load instead of stalling it.
module lsu_pipe #(
    parameter int ROB_TAG_W  = 4,
    parameter int PREG_W     = 6,
    parameter int DMEM_WORDS = 1024,
    parameter int SQ_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_i,
    input  logic                       mem_read_i,
    input  logic                       mem_write_i,
    input  logic [2:0]                 funct3_i,
    input  logic [31:0]                rs1_val_i,
    input  logic [31:0]                imm_i,
    input  logic [31:0]                rs2_val_i,
    input  logic [PREG_W-1:0]          rd_p_i,
    input  logic [ROB_TAG_W-1:0]       rob_tag_i,
    output logic                       ready_o,
    output logic                       valid_o,
    input  logic                       cdb_ready_i,
    output logic [31:0]                result_o,
    output logic [PREG_W-1:0]          rd_p_o,
    output logic [ROB_TAG_W-1:0]       rob_tag_o,
    output logic                       is_store_o,
    output logic                       exc_o,
    input  logic                       commit_store_i,
    input  logic                       flush_i,
    output logic [$clog2(SQ_DEPTH):0]  sq_count_o
);
    localparam int AW = $clog2(DMEM_WORDS);
    localparam int PW = $clog2(SQ_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0] r_mem [DMEM_WORDS] = '{default: '0};

    logic [AW-1:0]  r_sq_widx [SQ_DEPTH];
    logic [3:0]     r_sq_mask [SQ_DEPTH];
    logic [31:0]    r_sq_data [SQ_DEPTH];
    logic [PW-1:0]  r_head, r_tail;
    logic [CW-1:0]  r_count;

    logic                  r_s1_v, r_s1_store, r_s1_exc;
    logic [2:0]            r_s1_f3;
    logic [1:0]            r_s1_off;
    logic [PREG_W-1:0]     r_s1_rd;
    logic [ROB_TAG_W-1:0]  r_s1_tag;
    logic [31:0]           r_s1_data;

    logic                  r_out_v, r_out_store, r_out_exc;
    logic [31:0]           r_out_result;
    logic [PREG_W-1:0]     r_out_rd;
    logic [ROB_TAG_W-1:0]  r_out_tag;

    logic [31:0]    w_addr;
    logic [AW-1:0]  w_widx;
    logic [1:0]     w_off;
    logic           w_misal, w_unused;
    logic [3:0]     w_st_mask;
    logic [31:0]    w_st_data;
    logic [PW-1:0]  w_slot;
    logic           w_match, w_match_word, w_conflict, w_fwd;
    logic [31:0]    w_match_data, w_sh, w_fmt;
    logic           w_out_free, w_s1_adv, w_full, w_accept, w_enq, w_commit;

    assign w_addr   = rs1_val_i + imm_i;
    assign w_widx   = w_addr[AW+1:2];
    assign w_off    = w_addr[1:0];
    assign w_unused = ^w_addr[31:AW+2];

    always_comb begin
        case (funct3_i[1:0])
            2'b01:   w_misal = w_addr[0];
            2'b10:   w_misal = |w_addr[1:0];
            default: w_misal = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3_i[1:0])
            2'b00: begin
                w_st_mask = 4'b0001 << w_off;
                w_st_data = {24'b0, rs2_val_i[7:0]} << {w_off, 3'b000};
            end
            2'b01: begin
                w_st_mask = 4'b0011 << w_off;
                w_st_data = {16'b0, rs2_val_i[15:0]} << {w_off, 3'b000};
            end
            default: begin
                w_st_mask = 4'b1111;
                w_st_data = rs2_val_i;
            end
        endcase
    end

    // Walk occupied slots oldest to youngest so the last hit is the youngest.
    always_comb begin
        w_slot       = '0;
        w_match      = 1'b0;
        w_match_word = 1'b0;
        w_match_data = '0;
        for (int unsigned k = 0; k < SQ_DEPTH; k++) begin
            w_slot = r_head + PW'(k);
            if ((CW'(k) < r_count) && (r_sq_widx[w_slot] == w_widx)) begin
                w_match      = 1'b1;
                w_match_word = &r_sq_mask[w_slot];
                w_match_data = r_sq_data[w_slot];
            end
        end
    end

`ifdef LSU_STQ_FWD_EN
    assign w_conflict = w_match && !w_match_word;
    assign w_fwd      = w_match && w_match_word;
`else
    assign w_conflict = w_match;
    assign w_fwd      = 1'b0;
`endif

    assign w_out_free = !r_out_v || cdb_ready_i;
    assign w_s1_adv   = !r_s1_v || w_out_free;
    assign w_full     = (r_count == CW'(SQ_DEPTH));
    assign ready_o    = !flush_i && w_s1_adv &&
                        (mem_write_i ? !w_full : (mem_read_i ? !w_conflict : 1'b1));
    assign w_accept   = valid_i && ready_o;
    assign w_enq      = w_accept && mem_write_i && !w_misal;
    assign w_commit   = commit_store_i && (r_count != '0);

    // Load formatting happens on the S1 -> OUT transfer.
    assign w_sh = r_s1_data >> {r_s1_off, 3'b000};
    always_comb begin
        case (r_s1_f3)
            3'b000:  w_fmt = {{24{w_sh[7]}}, w_sh[7:0]};
            3'b100:  w_fmt = {24'b0, w_sh[7:0]};
            3'b001:  w_fmt = {{16{w_sh[15]}}, w_sh[15:0]};
            3'b101:  w_fmt = {16'b0, w_sh[15:0]};
            default: w_fmt = r_s1_data;
        endcase
        if (r_s1_store || r_s1_exc)
            w_fmt = '0;
    end

    // Storage without reset: memory, queue payload, S1 read data.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int unsigned b = 0; b < 4; b++)
                if (r_sq_mask[r_head][b])
                    r_mem[r_sq_widx[r_head]][8*b +: 8] <= r_sq_data[r_head][8*b +: 8];
        end
        if (w_enq) begin
            r_sq_widx[r_tail] <= w_widx;
            r_sq_mask[r_tail] <= w_st_mask;
            r_sq_data[r_tail] <= w_st_data;
        end
        if (w_accept)
            r_s1_data <= w_fwd ? w_match_data : r_mem[w_widx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v       <= 1'b0;
            r_s1_store   <= 1'b0;
            r_s1_exc     <= 1'b0;
            r_s1_f3      <= '0;
            r_s1_off     <= '0;
            r_s1_rd      <= '0;
            r_s1_tag     <= '0;
            r_out_v      <= 1'b0;
            r_out_store  <= 1'b0;
            r_out_exc    <= 1'b0;
            r_out_result <= '0;
            r_out_rd     <= '0;
            r_out_tag    <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
        end else begin
            if (w_out_free) begin
                r_out_v <= r_s1_v;
                if (r_s1_v) begin
                    r_out_result <= w_fmt;
                    r_out_rd     <= r_s1_store ? '0 : r_s1_rd;
                    r_out_tag    <= r_s1_tag;
                    r_out_store  <= r_s1_store;
                    r_out_exc    <= r_s1_exc;
                end
            end
            if (w_s1_adv)
                r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_store <= mem_write_i;
                r_s1_exc   <= w_misal;
                r_s1_f3    <= funct3_i;
                r_s1_off   <= w_off;
                r_s1_rd    <= rd_p_i;
                r_s1_tag   <= rob_tag_i;
            end
            if (flush_i) begin
                r_s1_v  <= 1'b0;
                r_out_v <= 1'b0;
            end

            if (w_commit)
                r_head <= r_head + PW'(1);
            // Flush keeps only what commits this edge: tail collapses onto new head.
            if (flush_i) begin
                r_tail  <= w_commit ? r_head + PW'(1) : r_head;
                r_count <= '0;
            end else begin
                if (w_enq)
                    r_tail <= r_tail + PW'(1);
                r_count <= r_count + CW'(w_enq) - CW'(w_commit);
            end
        end
    end

    assign valid_o    = r_out_v;
    assign result_o   = r_out_result;
    assign rd_p_o     = r_out_rd;
    assign rob_tag_o  = r_out_tag;
    assign is_store_o = r_out_store;
    assign exc_o      = r_out_exc;
    assign sq_count_o = r_count;

endmodule

// File: tb/tb_lsu_pipe.sv
module tb_lsu_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_val_i, imm_i, rs2_val_i;
    logic [5:0]  rd_p_i;
    logic [3:0]  rob_tag_i;
    logic        ready_o, valid_o, cdb_ready_i;
    logic [31:0] result_o;
    logic [5:0]  rd_p_o;
    logic [3:0]  rob_tag_o;
    logic        is_store_o, exc_o, commit_store_i, flush_i;
    logic [2:0]  sq_count_o;

    int n_cmp = 0;
    int n_bad = 0;

    bit          acc;
    int          lat;
    logic [31:0] res;
    logic        ex, st;
    logic [5:0]  rdo;
    logic [3:0]  tgo;

    lsu_pipe #(.ROB_TAG_W(4), .PREG_W(6), .DMEM_WORDS(1024), .SQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .funct3_i(funct3_i), .rs1_val_i(rs1_val_i),
        .imm_i(imm_i), .rs2_val_i(rs2_val_i), .rd_p_i(rd_p_i), .rob_tag_i(rob_tag_i),
        .ready_o(ready_o), .valid_o(valid_o), .cdb_ready_i(cdb_ready_i),
        .result_o(result_o), .rd_p_o(rd_p_o), .rob_tag_o(rob_tag_o),
        .is_store_o(is_store_o), .exc_o(exc_o), .commit_store_i(commit_store_i),
        .flush_i(flush_i), .sq_count_o(sq_count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic set_op(input bit ld, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] imm, input logic [31:0] data,
                          input logic [5:0] rd, input logic [3:0] tag);
        valid_i = 1'b1; mem_read_i = ld; mem_write_i = !ld; funct3_i = f3;
        rs1_val_i = base; imm_i = imm; rs2_val_i = data; rd_p_i = rd; rob_tag_i = tag;
    endtask

    task automatic clr_op();
        valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    endtask

    // Present one op, then wait (bounded) for its completion; lat counts
    // negedges after the accept edge (-1 if none within the budget).
    task automatic do_op(input bit ld, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] imm, input logic [31:0] data,
                         input logic [5:0] rd, input logic [3:0] tag);
        @(negedge clk);
        set_op(ld, f3, base, imm, data, rd, tag);
        #1 acc = ready_o;
        @(posedge clk);
        #1 clr_op();
        lat = -1; res = 'x; ex = 'x; st = 'x; rdo = 'x; tgo = 'x;
        if (acc) begin
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (valid_o) begin
                    lat = c; res = result_o; ex = exc_o; st = is_store_o;
                    rdo = rd_p_o; tgo = rob_tag_o;
                    break;
                end
            end
        end
    endtask

    task automatic commit_one();
        @(negedge clk);
        commit_store_i = 1'b1;
        @(posedge clk);
        #1 commit_store_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid_o); end
        n_cmp++; if (result_o !== 32'h0) begin n_bad++; $display("FAIL rst_result: got %h want 0", result_o); end
        n_cmp++; if ({rd_p_o, rob_tag_o, is_store_o, exc_o} !== 12'h0) begin n_bad++;
            $display("FAIL rst_fields: got %h want 000", {rd_p_o, rob_tag_o, is_store_o, exc_o}); end
        n_cmp++; if (sq_count_o !== 3'd0) begin n_bad++; $display("FAIL rst_sqcount: got %0d want 0", sq_count_o); end
        rst = 1'b0;
    endtask

    task automatic test_lw();
        do_op(1'b0, 3'b010, 32'h8, 32'h8, 32'hDEADBEEF, 6'd0, 4'd1);
        n_cmp++; if (!acc || lat != 2) begin n_bad++; $display("FAIL sw_latency: got acc=%0d lat=%0d want 1/2", acc, lat); end
        n_cmp++; if ({st, res, tgo} !== {1'b1, 32'h0, 4'd1}) begin n_bad++;
            $display("FAIL sw_completion: got st=%b res=%h tag=%h want 1/0/1", st, res, tgo); end
        n_cmp++; if (sq_count_o !== 3'd1) begin n_bad++; $display("FAIL sw_sqcount: got %0d want 1", sq_count_o); end
        commit_one();
        @(negedge clk);
        n_cmp++; if (sq_count_o !== 3'd0) begin n_bad++; $display("FAIL commit_sqcount: got %0d want 0", sq_count_o); end
        do_op(1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 6'd33, 4'd9);
        n_cmp++; if (!acc || lat != 2) begin n_bad++; $display("FAIL lw_latency: got acc=%0d lat=%0d want 1/2", acc, lat); end
        n_cmp++; if (res !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_result: got %h want deadbeef", res); end
        n_cmp++; if ({rdo, tgo, st, ex} !== {6'd33, 4'd9, 1'b0, 1'b0}) begin n_bad++;
            $display("FAIL lw_echo: got rd=%0d tag=%0d st=%b ex=%b want 33/9/0/0", rdo, tgo, st, ex); end
        @(negedge clk);
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL lw_popped: got %b want 0", valid_o); end
    endtask

    task automatic test_byte_half();
        do_op(1'b0, 3'b000, 32'h20, 32'h1, 32'h12345680, 6'd0, 4'd2);
        commit_one();
        do_op(1'b1, 3'b000, 32'h21, 32'h0, 32'h0, 6'd4, 4'd3);
        n_cmp++; if (lat != 2 || res !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb: got lat=%0d %h want 2/ffffff80", lat, res); end
        do_op(1'b1, 3'b100, 32'h21, 32'h0, 32'h0, 6'd4, 4'd3);
        n_cmp++; if (res !== 32'h00000080) begin n_bad++; $display("FAIL lbu: got %h want 00000080", res); end
        do_op(1'b1, 3'b001, 32'h20, 32'h0, 32'h0, 6'd4, 4'd3);
        n_cmp++; if (res !== 32'hFFFF8000) begin n_bad++; $display("FAIL lh: got %h want ffff8000", res); end
        do_op(1'b1, 3'b101, 32'h1E, 32'h2, 32'h0, 6'd4, 4'd3);
        n_cmp++; if (res !== 32'h00008000) begin n_bad++; $display("FAIL lhu: got %h want 00008000", res); end
    endtask

    task automatic test_sq_full();
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, 3'b010, 32'h100, 32'(4 * i), 32'(32'hA0 + i), 6'd0, 4'(i));
            n_cmp++; if (!acc) begin n_bad++; $display("FAIL sq_enq%0d: got 0 want 1", i); end
        end
        @(negedge clk);
        n_cmp++; if (sq_count_o !== 3'd4) begin n_bad++; $display("FAIL sq_full_count: got %0d want 4", sq_count_o); end
        set_op(1'b0, 3'b010, 32'h110, 32'h0, 32'hA4, 6'd0, 4'd4);
        #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL sq_full_ready: got %b want 0", ready_o); end
        commit_store_i = 1'b1;
        #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL sq_commit_same_cycle: got %b want 0", ready_o); end
        @(posedge clk);
        #1 commit_store_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (sq_count_o !== 3'd3) begin n_bad++; $display("FAIL sq_after_commit: got %0d want 3", sq_count_o); end
        #1;
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL sq_next_cycle_ready: got %b want 1", ready_o); end
        @(posedge clk);
        #1 clr_op();
        @(negedge clk);
        n_cmp++; if (sq_count_o !== 3'd4) begin n_bad++; $display("FAIL sq_wrap_count: got %0d want 4", sq_count_o); end
        repeat (4) commit_one();
        @(negedge clk);
        n_cmp++; if (sq_count_o !== 3'd0) begin n_bad++; $display("FAIL sq_drained: got %0d want 0", sq_count_o); end
        do_op(1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 6'd1, 4'd1);
        n_cmp++; if (res !== 32'hA0) begin n_bad++; $display("FAIL sq_mem0: got %h want 000000a0", res); end
        do_op(1'b1, 3'b010, 32'h110, 32'h0, 32'h0, 6'd1, 4'd1);
        n_cmp++; if (res !== 32'hA4) begin n_bad++; $display("FAIL sq_mem4: got %h want 000000a4", res); end
    endtask

    task automatic test_fwd();
        do_op(1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 6'd0, 4'd3);
`ifdef LSU_STQ_FWD_EN
        do_op(1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 6'd7, 4'd6);
        n_cmp++; if (!acc || lat != 2 || res !== 32'hCAFEF00D) begin n_bad++;
            $display("FAIL fwd_lw: got acc=%0d lat=%0d %h want 1/2/cafef00d", acc, lat, res); end
        do_op(1'b1, 3'b100, 32'h43, 32'h0, 32'h0, 6'd7, 4'd6);
        n_cmp++; if (res !== 32'h000000CA) begin n_bad++; $display("FAIL fwd_lbu: got %h want 000000ca", res); end
`else
        @(negedge clk);
        set_op(1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 6'd7, 4'd6);
        #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL conflict_stall: got %b want 0", ready_o); end
        @(posedge clk);
        #1 clr_op();
`endif
        do_op(1'b0, 3'b000, 32'h44, 32'h0, 32'h55, 6'd0, 4'd4);
        @(negedge clk);
        set_op(1'b1, 3'b010, 32'h44, 32'h0, 32'h0, 6'd7, 4'd6);
        #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL byte_conflict_stall: got %b want 0", ready_o); end
        @(posedge clk);
        #1 clr_op();
        repeat (2) commit_one();
        do_op(1'b1, 3'b010, 32'h44, 32'h0, 32'h0, 6'd7, 4'd6);
        n_cmp++; if (res !== 32'h00000055) begin n_bad++; $display("FAIL sb_committed: got %h want 00000055", res); end
        do_op(1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 6'd7, 4'd6);
        n_cmp++; if (res !== 32'hCAFEF00D) begin n_bad++; $display("FAIL sw_committed: got %h want cafef00d", res); end
        do_op(1'b0, 3'b010, 32'h42, 32'h0, 32'h99999999, 6'd0, 4'd8);
        n_cmp++; if ({ex, st, res} !== {1'b1, 1'b1, 32'h0}) begin n_bad++;
            $display("FAIL misaligned_sw: got ex=%b st=%b %h want 1/1/0", ex, st, res); end
        n_cmp++; if (sq_count_o !== 3'd0) begin n_bad++; $display("FAIL misaligned_not_queued: got %0d want 0", sq_count_o); end
    endtask

    task automatic test_back_to_back();
        int          i = 0, n = 0;
        bit          acc_now, pstall = 1'b0;
        logic [31:0] pres = '0;
        logic [3:0]  ptag = '0;
        logic [31:0] got [3];
        logic [3:0]  gtag [3];
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            cdb_ready_i = !(cyc >= 2 && cyc <= 4);
            if (valid_o && pstall) begin
                n_cmp++; if (result_o !== pres || rob_tag_o !== ptag) begin n_bad++;
                    $display("FAIL hold_c%0d: got %h/%h want %h/%h", cyc, result_o, rob_tag_o, pres, ptag); end
            end
            pstall = valid_o && !cdb_ready_i;
            pres = result_o; ptag = rob_tag_o;
            if (valid_o && cdb_ready_i && n < 3) begin got[n] = result_o; gtag[n] = rob_tag_o; n++; end
            if (i < 3) set_op(1'b1, 3'b010, 32'h100, 32'(4 * i), 32'h0, 6'(10 + i), 4'(5 + i));
            else clr_op();
            #1 acc_now = valid_i && ready_o;
            @(posedge clk);
            #1 if (acc_now) i++;
        end
        cdb_ready_i = 1'b1;
        clr_op();
        n_cmp++; if (n != 3) begin n_bad++; $display("FAIL b2b_delivered: got %0d want 3", n); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (got[k] !== 32'(32'hA0 + k) || gtag[k] !== 4'(5 + k)) begin n_bad++;
                $display("FAIL b2b_order%0d: got %h/%h want %h/%h", k, got[k], gtag[k], 32'hA0 + k, 5 + k); end
        end
        do_op(1'b1, 3'b001, 32'h3, 32'h0, 32'h0, 6'd2, 4'd2);
        n_cmp++; if (lat != 2 || {ex, res} !== {1'b1, 32'h0}) begin n_bad++;
            $display("FAIL lh_misaligned: got lat=%0d ex=%b %h want 2/1/0", lat, ex, res); end
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        do_op(1'b0, 3'b010, 32'h80, 32'h0, 32'h11111111, 6'd0, 4'd1);
        do_op(1'b0, 3'b010, 32'h84, 32'h0, 32'h22222222, 6'd0, 4'd2);
        n_cmp++; if (sq_count_o !== 3'd2) begin n_bad++; $display("FAIL flush_pre_count: got %0d want 2", sq_count_o); end
        @(negedge clk);
        set_op(1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 6'd5, 4'd12);
        #1;
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_inflight_accept: got %b want 1", ready_o); end
        @(posedge clk);
        #1 clr_op();
        @(negedge clk);
        flush_i = 1'b1; commit_store_i = 1'b1;
        set_op(1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 6'd5, 4'd13);
        #1;
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", ready_o); end
        @(posedge clk);
        #1 begin flush_i = 1'b0; commit_store_i = 1'b0; clr_op(); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL flush_squash: got valid 1 want 0"); end
        n_cmp++; if (sq_count_o !== 3'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", sq_count_o); end
        do_op(1'b1, 3'b010, 32'h80, 32'h0, 32'h0, 6'd5, 4'd1);
        n_cmp++; if (res !== 32'h11111111) begin n_bad++; $display("FAIL flush_commit_written: got %h want 11111111", res); end
        do_op(1'b1, 3'b010, 32'h84, 32'h0, 32'h0, 6'd5, 4'd1);
        n_cmp++; if (res !== 32'h0) begin n_bad++; $display("FAIL flush_dropped: got %h want 00000000", res); end
        do_op(1'b0, 3'b010, 32'h88, 32'h0, 32'h33333333, 6'd0, 4'd3);
        n_cmp++; if (sq_count_o !== 3'd1) begin n_bad++; $display("FAIL flush_requeue: got %0d want 1", sq_count_o); end
        commit_one();
        do_op(1'b1, 3'b010, 32'h88, 32'h0, 32'h0, 6'd5, 4'd1);
        n_cmp++; if (res !== 32'h33333333) begin n_bad++; $display("FAIL flush_ptrs: got %h want 33333333", res); end
    endtask

    task automatic test_reset_mid();
        do_op(1'b0, 3'b010, 32'h90, 32'h0, 32'h44444444, 6'd0, 4'd1);
        @(negedge clk);
        set_op(1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 6'd9, 4'd9);
        @(posedge clk);
        #1 clr_op();
        @(posedge clk);
        #1;
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: got %b want 1", valid_o); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({valid_o, result_o, sq_count_o} !== 36'h0) begin n_bad++;
            $display("FAIL rstmid_async: got v=%b %h cnt=%0d want 0/0/0", valid_o, result_o, sq_count_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cdb_ready_i = 1'b1; commit_store_i = 1'b0; flush_i = 1'b0;
        funct3_i = '0; rs1_val_i = '0; imm_i = '0; rs2_val_i = '0; rd_p_i = '0; rob_tag_i = '0;
        clr_op();
        test_reset();
        test_lw();
        test_byte_half();
        test_sq_full();
        test_fwd();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lsu_pipe.md
Name: lsu_pipe

Overview:
- Pipelined load/store unit replacing the single-request load FSM; one op accepted per cycle, loads and stores, byte/half/word with sign/zero extension.
- Sits between the LSU reservation station and the CDB.
- Holds stores in a SQ_DEPTH store queue that drains to data memory only on ROB commit.
- Flush discards uncommitted stores and in-flight ops.

Parameters:
- ROB_TAG_W, 4, ROB tag width.
- PREG_W, 6, physical register index width.
- DMEM_WORDS, 1024, data memory depth in 32-bit words (power of 2); word index = addr[$clog2(DMEM_WORDS)+1:2].
- SQ_DEPTH, 4, store queue entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- valid_i  in  1  op presented by RS
- mem_read_i  in  1  op is load
- mem_write_i  in  1  op is store (never both)
- funct3_i  in  3  RV32 size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
- rs1_val_i  in  32  base
- imm_i  in  32  offset
- rs2_val_i  in  32  store data
- rd_p_i  in  PREG_W  destination preg
- rob_tag_i  in  ROB_TAG_W  ROB tag
- ready_o  out  1  op accepted this cycle if valid_i
- valid_o  out  1  CDB result valid
- cdb_ready_i  in  1  CDB takes result this cycle
- result_o  out  32  load data (0 for stores)
- rd_p_o  out  PREG_W  dest preg (0 for stores)
- rob_tag_o  out  ROB_TAG_W  ROB tag
- is_store_o  out  1  completion belongs to a store
- exc_o  out  1  misaligned access
- commit_store_i  in  1  ROB commits oldest store
- flush_i  in  1  squash
- sq_count_o  out  $clog2(SQ_DEPTH)+1  store queue occupancy

Behaviour:
- Reset (async): S1/OUT valid = 0, SQ empty; valid_o=0, result_o=0, rd_p_o=0, rob_tag_o=0, is_store_o=0, exc_o=0, sq_count_o=0. Memory contents not reset (zero-initialised at time 0).
- Accept = valid_i && ready_o. Address = rs1_val_i + imm_i, 32-bit wrap.
- Pipeline:
  - Accept edge: registered memory read into S1.
  - S1 -> OUT when OUT empty or popped (valid_o && cdb_ready_i).
  - Load valid_o first high exactly 2 cycles after accept edge with no stall; sustained 1 op/cycle.
  - OUT holds stable while valid_o && !cdb_ready_i.
- ready_o = !flush_i && (S1 empty or S1 advancing), and:
  - store: SQ not full;
  - load: no SQ entry with equal word index.
  - Full/conflict are evaluated on pre-commit SQ contents (same-cycle commit does not unblock).
- Load format: byte/half selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- Misaligned (half with addr[0]=1, word with addr[1:0]!=0): op still flows, exc_o=1, result_o=0; a store is not enqueued.
- Store: enqueued at accept (word index, byte mask, shifted data); completion reaches CDB at same 2-cycle latency with is_store_o=1.
- commit_store_i with SQ non-empty: head written to memory by byte mask that edge, popped. Commit with SQ empty ignored.
- Simultaneous enqueue and commit: count unchanged; head/tail pointers wrap modulo SQ_DEPTH.
- flush_i:
  - next edge clears S1, OUT, and all SQ entries not committed that cycle;
  - commit in same cycle still writes head;
  - no acceptance in flush cycle.

Optional Feature:
- LSU_STQ_FWD_EN defined: load matching a SQ word-sized store (youngest matching entry) is accepted; its data is forwarded in place of memory and formatted normally. Matches against byte/half stores still stall.
- Undefined: any word-index match stalls.

Test Plan:
- LW 0x10 after memory word 4 = 0xDEADBEEF preloaded -> valid_o cycle 2, result 0xDEADBEEF, rd_p/tag echoed.
- SB 0x80 to addr 0x21, commit, then LB 0x21 -> result 0xFFFFFF80; LBU -> 0x00000080; LH 0x20 -> 0xFFFF8000.
- SQ_DEPTH=4: five stores, no commit -> ready_o low on fifth, sq_count_o=4; commit + 5th store same cycle -> still blocked that cycle, accepted next.
- SW 0xCAFEF00D to 0x40 uncommitted, LW 0x40 -> stall (fwd off) / result 0xCAFEF00D cycle 2 (LSU_STQ_FWD_EN).
- cdb_ready_i=0 for 3 cycles with 3 back-to-back loads -> outputs held, no loss, in-order delivery; LH at 0x3 -> exc_o=1.
- 2 stores queued, commit + flush same cycle -> first written, sq_count_o=0, second never in memory; rst mid-load -> valid_o 0 immediately.
